// File: rtl/aes_inv_cntx_if.sv
// Bus between the AES-128 inverse round controller and the AES core:
// the start request plus every step enable and status the controller drives.
interface aes_inv_cntx_if;
    logic       start;
    logic       accept;
    logic       ldKey;
    logic       ldData;
    logic [3:0] rndNo;
    logic       enbISB;
    logic       enbISR;
    logic       enbIMC;
    logic       enbAR;
    logic       enbKSF;
    logic       enbKSI;
    logic       busy;
    logic       done;

    // Controller side
    modport master (
        input  start,
        output accept, ldKey, ldData, rndNo,
        output enbISB, enbISR, enbIMC, enbAR, enbKSF, enbKSI,
        output busy, done
    );

    // Core / requester side
    modport slave (
        output start,
        input  accept, ldKey, ldData, rndNo,
        input  enbISB, enbISR, enbIMC, enbAR, enbKSF, enbKSI,
        input  busy, done
    );
endinterface

// File: rtl/aes_inv_cntx.sv
// AES-128 inverse-cipher round sequencer. It optionally runs a forward
// key-expansion pass to reach round key NR, then walks the rounds down from
// NR to 0. Step enables are registered, decoded from the next state so that
// they line up with the state they belong to. rndNo is the counter itself:
// the counter holds 0 in IDLE and FINAL and NR in INIT, so no decode is needed.
module aes_inv_cntx #(
    parameter int NR        = 10,
    parameter bit SKIP_KEXP = 1'b0
) (
    input  logic          clk,
    input  logic          rstn,
    aes_inv_cntx_if.master bus
);
    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} state_t;

    localparam logic [3:0] NR4 = 4'(NR);

    state_t     state, nState;
    logic [3:0] cnt, nCnt;
    logic       isb, isr, imc, ar, ksf, ksi, busyR, doneR;
    logic       acc;

    // Next-state and counter; a dropped start in any active state aborts to IDLE
    always_comb begin
        nState = state;
        nCnt   = cnt;
        if (state != IDLE && !bus.start) begin
            nState = IDLE;
            nCnt   = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (SKIP_KEXP) begin
                            nState = INIT;
                            nCnt   = NR4;
                        end else begin
                            nState = KEXP;
                            nCnt   = 4'd1;
                        end
                    end
                end
                KEXP: begin
                    if (cnt == NR4) begin
                        nState = INIT;
                    end else begin
                        nCnt = cnt + 4'd1;
                    end
                end
                INIT: begin
                    if (NR4 == 4'd1) begin
                        nState = FINAL;
                        nCnt   = 4'd0;
                    end else begin
                        nState = ROUND;
                        nCnt   = NR4 - 4'd1;
                    end
                end
                ROUND: begin
                    if (cnt == 4'd1) begin
                        nState = FINAL;
                        nCnt   = 4'd0;
                    end else begin
                        nCnt = cnt - 4'd1;
                    end
                end
                FINAL: begin
                    nState = IDLE;
                    nCnt   = 4'd0;
                end
                default: begin
                    nState = IDLE;
                    nCnt   = 4'd0;
                end
            endcase
        end
    end

    // State, counter and Moore outputs registered together
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= 4'd0;
            isb   <= 1'b0;
            isr   <= 1'b0;
            imc   <= 1'b0;
            ar    <= 1'b0;
            ksf   <= 1'b0;
            ksi   <= 1'b0;
            busyR <= 1'b0;
            doneR <= 1'b0;
        end else begin
            state <= nState;
            cnt   <= nCnt;
            ksf   <= (nState == KEXP);
            ar    <= (nState == INIT) || (nState == ROUND) || (nState == FINAL);
            isr   <= (nState == ROUND) || (nState == FINAL);
            isb   <= (nState == ROUND) || (nState == FINAL);
            ksi   <= (nState == ROUND) || (nState == FINAL);
            imc   <= (nState == ROUND);
            busyR <= (nState != IDLE);
            doneR <= (nState == FINAL);
        end
    end

    // Only the load strobes see start combinationally, gated by idle
    assign acc        = (state == IDLE);
    assign bus.accept = acc;
    assign bus.ldKey  = acc & bus.start;
    assign bus.ldData = acc & bus.start;
    assign bus.rndNo  = cnt;
    assign bus.enbISB = isb;
    assign bus.enbISR = isr;
    assign bus.enbIMC = imc;
    assign bus.enbAR  = ar;
    assign bus.enbKSF = ksf;
    assign bus.enbKSI = ksi;
    assign bus.busy   = busyR;
    assign bus.done   = doneR;
endmodule

// File: tb/tb_aes_inv_cntx.sv
// Directed bench for aes_inv_cntx: one instance with key expansion, one with
// SKIP_KEXP=1. Outputs are packed as {accept,busy,done,KSF,KSI,ISR,ISB,IMC,AR,rndNo}.
module tb_aes_inv_cntx;
    localparam int NR = 10;

    logic clk = 1'b0;
    logic rstn;
    int   nVec = 0;
    int   nErr = 0;

    aes_inv_cntx_if ifA ();
    aes_inv_cntx_if ifB ();

    aes_inv_cntx #(.NR(NR), .SKIP_KEXP(1'b0)) dutA (.clk(clk), .rstn(rstn), .bus(ifA));
    aes_inv_cntx #(.NR(NR), .SKIP_KEXP(1'b1)) dutB (.clk(clk), .rstn(rstn), .bus(ifB));

    always #5 clk = ~clk;

    function automatic logic [12:0] pk(logic acc, logic bsy, logic dn, logic ksf, logic ksi,
                                       logic isr, logic isb, logic imc, logic ar, logic [3:0] rnd);
        return {acc, bsy, dn, ksf, ksi, isr, isb, imc, ar, rnd};
    endfunction

    localparam logic [12:0] IDLEV = 13'h1000;

    // Expected outputs in cycle k after the start-sampling edge
    function automatic logic [12:0] expRun(int k, bit skip);
        int n;
        n = skip ? k + NR : k;
        if (n <= NR)          return pk(0, 1, 0, 1, 0, 0, 0, 0, 0, 4'(n));
        else if (n == NR + 1) return pk(0, 1, 0, 0, 0, 0, 0, 0, 1, 4'(NR));
        else if (n <= 2 * NR) return pk(0, 1, 0, 0, 1, 1, 1, 1, 1, 4'(2 * NR + 1 - n));
        else                  return pk(0, 1, 1, 0, 1, 1, 1, 0, 1, 4'd0);
    endfunction

    function automatic logic [12:0] obsA();
        return pk(ifA.accept, ifA.busy, ifA.done, ifA.enbKSF, ifA.enbKSI,
                  ifA.enbISR, ifA.enbISB, ifA.enbIMC, ifA.enbAR, ifA.rndNo);
    endfunction

    function automatic logic [12:0] obsB();
        return pk(ifB.accept, ifB.busy, ifB.done, ifB.enbKSF, ifB.enbKSI,
                  ifB.enbISR, ifB.enbISB, ifB.enbIMC, ifB.enbAR, ifB.rndNo);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample and drive 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runA(input int upTo, input string name);
        for (int k = 1; k <= upTo; k++) begin
            tick();
            chk($sformatf("%s c%0d", name, k), 32'(obsA()), 32'(expRun(k, 1'b0)));
        end
    endtask

    initial begin
        logic seenDone;
        rstn      = 1'b0;
        ifA.start = 1'b0;
        ifB.start = 1'b0;
        repeat (2) tick();
        chk("rst A", 32'(obsA()), 32'(IDLEV));
        chk("rst B", 32'(obsB()), 32'(IDLEV));
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle A %0d", i), 32'(obsA()), 32'(IDLEV));
            chk($sformatf("idle B %0d", i), 32'(obsB()), 32'(IDLEV));
        end
        chk("ldKey idle nostart", 32'({ifA.ldKey, ifA.ldData}), 32'(2'b00));

        // Full run with key expansion, start held high
        ifA.start = 1'b1;
        #1;
        chk("ld pre E0", 32'({ifA.ldKey, ifA.ldData}), 32'(2'b11));
        runA(2 * NR + 1, "full");
        // Back-to-back: one IDLE cycle with loads, then KEXP round 1
        tick();
        chk("b2b idle", 32'(obsA()), 32'(IDLEV));
        chk("b2b ldKey", 32'({ifA.ldKey, ifA.ldData}), 32'(2'b11));
        tick();
        chk("b2b kexp", 32'(obsA()), 32'(expRun(1, 1'b0)));
        ifA.start = 1'b0;
        tick();
        chk("abort kexp", 32'(obsA()), 32'(IDLEV));

        // Skip-key-expansion instance
        ifB.start = 1'b1;
        seenDone  = 1'b0;
        for (int k = 1; k <= NR + 1; k++) begin
            tick();
            chk($sformatf("skip c%0d", k), 32'(obsB()), 32'(expRun(k, 1'b1)));
            if (ifB.enbKSF) seenDone = 1'b1;
        end
        chk("skip no KSF", 32'(seenDone), 32'(1'b0));
        ifB.start = 1'b0;
        tick();
        chk("skip idle", 32'(obsB()), 32'(IDLEV));

        // Abort during ROUND at rndNo=5, then a clean restart
        ifA.start = 1'b1;
        runA(16, "abrt");
        chk("abrt at 5", 32'(ifA.rndNo), 32'd5);
        ifA.start = 1'b0;
        tick();
        chk("abrt idle", 32'(obsA()), 32'(IDLEV));
        seenDone = 1'b0;
        repeat (3) begin
            tick();
            if (ifA.done) seenDone = 1'b1;
        end
        chk("abrt no done", 32'(seenDone), 32'(1'b0));
        ifA.start = 1'b1;
        runA(2 * NR + 1, "restart");
        ifA.start = 1'b0;
        tick();
        chk("restart idle", 32'(obsA()), 32'(IDLEV));

        // Asynchronous reset in the middle of KEXP
        ifA.start = 1'b1;
        runA(4, "arst");
        #2;
        rstn = 1'b0;
        #1;
        chk("arst out", 32'(obsA()), 32'(IDLEV));
        chk("arst ld", 32'({ifA.ldKey, ifA.ldData}), 32'(2'b11));
        ifA.start = 1'b0;
        tick();
        rstn = 1'b1;
        seenDone = 1'b0;
        repeat (2 * NR + 4) begin
            tick();
            if (ifA.done || ifA.busy) seenDone = 1'b1;
        end
        chk("arst quiet", 32'(seenDone), 32'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
